ncpu32k_ibus_responder: RTL and testbench
=========================================

Name: ncpu32k_ibus_responder

Overview:
- Slave/responder end of the instruction-fetch A/B channel driven by the IMMU (icache_AVALID/AREADY/AADDR/AEXC).
- Accepts one translated fetch request at a time and forwards it to a simple memory port, or short-circuits it when an MMU exception is flagged.
- Returns instruction data plus exception status on a B channel.
- Serves as a cacheless fetch backend and as the bench responder for the IMMU.

Parameters:
- CONFIG_EXC_INSN, 32'h0000_0000: BDATA driven on any exception response.
- CONFIG_PIPEBUF_BYPASS, 1: 1 = AREADY may assert in RESP when BREADY=1 (back-to-back); 0 = AREADY only in IDLE.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- icache_AVALID  in  1  request valid
- icache_AREADY  out  1  request accepted when AVALID&AREADY
- icache_AADDR  in  32  physical fetch address
- icache_AEXC  in  2  [0] tlb miss, [1] page fault
- icache_BVALID  out  1  response valid
- icache_BREADY  in  1  response consumed when BVALID&BREADY
- icache_BDATA  out  32  instruction word
- icache_BEXC  out  3  [0] tlb miss, [1] page fault, [2] misaligned/bus error
- mem_AVALID  out  1  memory read request
- mem_AREADY  in  1  memory accepts request
- mem_AADDR  out  32  word address, [1:0] forced 0
- mem_BVALID  in  1  memory read data valid (single-cycle pulse, no backpressure)
- mem_BDATA  in  32  memory read data

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- FSM states: IDLE, MEM_A, MEM_B, RESP.
- Reset (async, any state): state=IDLE; AREADY=1, BVALID=0, BEXC=0, BDATA=0, mem_AVALID=0, mem_AADDR=0. An in-flight memory transaction is abandoned; the memory side shares reset.
- IDLE: AREADY=1. On accept, latch AADDR and AEXC.
  - AEXC!=0: go to RESP with BEXC={1'b0,AEXC}, BDATA=CONFIG_EXC_INSN. Memory is never touched. BVALID=1 at accept+1.
  - AEXC==0: go to MEM_A.
- MEM_A: mem_AVALID=1, mem_AADDR={addr[31:2],2'b0}, both held stable until mem_AREADY. Then go to MEM_B.
- MEM_B: wait for mem_BVALID. Capture mem_BDATA into BDATA with BEXC=0, then go to RESP.
- mem_BVALID arriving in the same cycle as mem_AREADY is legal. Capture it and go MEM_A->RESP directly.
- Minimum latency with no exception and zero-wait memory: accept at cycle 0, mem_AVALID cycle 1, BVALID cycle 2. With a 1-cycle data return, BVALID appears at cycle 3.
- RESP: BVALID=1; BDATA/BEXC held stable until BREADY.
  - On BREADY, return to IDLE.
  - With CONFIG_PIPEBUF_BYPASS=1, AREADY=BREADY in RESP. A simultaneous accept goes straight to the new request's next state (MEM_A or RESP), so BVALID stays high for the next exception response.
- AEXC==2'b11 is illegal upstream. Pass through unchanged; an assertion flags it.
- mem_BVALID outside MEM_A/MEM_B is ignored; an assertion flags it.
- Single outstanding request only; no queuing.

Optional Feature:
- Macro: NCPU_IBUS_RESP_ALIGN_CHECK_EN
- Defined: an accept with AEXC==0 and AADDR[1:0]!=0 goes directly to RESP with BEXC=3'b100 and BDATA=CONFIG_EXC_INSN, without accessing memory. AEXC takes priority over misalignment.
- Undefined: AADDR[1:0] is ignored; the word at {AADDR[31:2],2'b0} is returned and BEXC[2] is always 0.

Decomposition:
- Shared package/config header:
  - exception bit indices (EXC_ITM=0, EXC_IPF=1, EXC_BUS=2);
  - BEXC width 3;
  - 2-bit state encoding IDLE=0, MEM_A=1, MEM_B=2, RESP=3.
- Registers use the existing nDFF_lr/nDFF_r cells.
- No further sub-module is natural; the FSM plus a handful of load-enabled registers is a single module.

Test Plan:
- Zero-wait memory, AADDR=32'h0000_1004, AEXC=0, mem returns 32'hDEAD_BEEF -> mem_AADDR=32'h0000_1004, BDATA=32'hDEAD_BEEF, BEXC=0, BVALID at accept+2 or accept+3.
- AEXC=2'b01, AADDR=32'h8000_0000 -> mem_AVALID never asserts; BVALID at accept+1, BEXC=3'b001, BDATA=CONFIG_EXC_INSN.
- mem_AREADY stalled 4 cycles, BREADY low 3 cycles -> mem_AADDR stable throughout the stall; BDATA/BEXC stable while BVALID&~BREADY; no second accept.
- CONFIG_PIPEBUF_BYPASS=1: back-to-back requests with BREADY=1 -> second accept in the same cycle as first B handshake; responses in order, no dropped or duplicated BVALID.
- With NCPU_IBUS_RESP_ALIGN_CHECK_EN: AADDR=32'h0000_2002, AEXC=0 -> BEXC=3'b100, no memory access. AADDR=32'h0000_2002, AEXC=2'b10 -> BEXC=3'b010.
- rst_n asserted while in MEM_B -> immediately AREADY=1, BVALID=0, mem_AVALID=0; after release, a fresh request completes normally with correct data.

Source files
------------

// File: rtl/ncpu32k_ibus_responder_pkg.sv
// Shared definitions for the instruction-bus responder: exception bit
// positions, response exception width and the FSM state encoding.
package ncpu32k_ibus_responder_pkg;

  localparam int EXC_ITM = 0;
  localparam int EXC_IPF = 1;
  localparam int EXC_BUS = 2;
  localparam int BEXC_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MEM_A = 2'd1,
    ST_MEM_B = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/ncpu32k_ibus_responder_dff.sv
// Load-enabled register with asynchronous active-low reset to a fixed value,
// in the style of the nDFF_lr cell.
module ncpu32k_ibus_responder_dff #(
  parameter int              DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= RST_VAL;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/ncpu32k_ibus_responder.sv
// Instruction-fetch A/B channel responder: forwards one request at a time to a
// simple memory port or answers MMU exceptions directly.
// Optional: NCPU_IBUS_RESP_ALIGN_CHECK_EN flags misaligned fetches as bus errors.
module ncpu32k_ibus_responder
  import ncpu32k_ibus_responder_pkg::*;
#(
  parameter logic [31:0] CONFIG_EXC_INSN       = 32'h0000_0000,
  parameter int          CONFIG_PIPEBUF_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_AVALID,
  output logic              icache_AREADY,
  input  logic [31:0]       icache_AADDR,
  input  logic [1:0]        icache_AEXC,
  output logic              icache_BVALID,
  input  logic              icache_BREADY,
  output logic [31:0]       icache_BDATA,
  output logic [BEXC_W-1:0] icache_BEXC,
  output logic              mem_AVALID,
  input  logic              mem_AREADY,
  output logic [31:0]       mem_AADDR,
  input  logic              mem_BVALID,
  input  logic [31:0]       mem_BDATA
);

  state_t            state, state_nxt;
  logic              ld_addr, ld_resp;
  logic [31:0]       resp_data;
  logic [BEXC_W-1:0] resp_exc;
  logic [31:0]       addr_r;
  logic              misalign;
  logic              acc_mmu_exc, acc_bus_exc, acc_short;
  logic [BEXC_W-1:0] acc_exc;

`ifdef NCPU_IBUS_RESP_ALIGN_CHECK_EN
  assign misalign = |icache_AADDR[1:0];
`else
  assign misalign = 1'b0;
`endif

  // MMU exceptions outrank misalignment; either one bypasses memory entirely.
  assign acc_mmu_exc = |icache_AEXC;
  assign acc_bus_exc = ~acc_mmu_exc & misalign;
  assign acc_short   = acc_mmu_exc | acc_bus_exc;
  assign acc_exc     = {acc_bus_exc, icache_AEXC};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    icache_AREADY = 1'b0;
    mem_AVALID    = 1'b0;
    ld_addr       = 1'b0;
    ld_resp       = 1'b0;
    resp_data     = mem_BDATA;
    resp_exc      = '0;
    case (state)
      ST_IDLE: begin
        icache_AREADY = 1'b1;
        if (icache_AVALID) begin
          ld_addr = 1'b1;
          if (acc_short) begin
            ld_resp   = 1'b1;
            resp_data = CONFIG_EXC_INSN;
            resp_exc  = acc_exc;
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_MEM_A;
          end
        end
      end
      ST_MEM_A: begin
        mem_AVALID = 1'b1;
        if (mem_AREADY) begin
          if (mem_BVALID) begin
            ld_resp   = 1'b1;
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_MEM_B;
          end
        end
      end
      ST_MEM_B: begin
        if (mem_BVALID) begin
          ld_resp   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        icache_AREADY = (CONFIG_PIPEBUF_BYPASS != 0) && icache_BREADY;
        if (icache_BREADY) begin
          state_nxt = ST_IDLE;
          // Back-to-back accept: the new request replaces the drained response.
          if (icache_AVALID && (CONFIG_PIPEBUF_BYPASS != 0)) begin
            ld_addr = 1'b1;
            if (acc_short) begin
              ld_resp   = 1'b1;
              resp_data = CONFIG_EXC_INSN;
              resp_exc  = acc_exc;
              state_nxt = ST_RESP;
            end else begin
              state_nxt = ST_MEM_A;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign icache_BVALID = (state == ST_RESP);
  assign mem_AADDR     = addr_r & 32'hFFFF_FFFC;

  ncpu32k_ibus_responder_dff #(.DATA_W(32)) addr_ff (
    .clk(clk), .rst_n(rst_n), .load(ld_addr), .d(icache_AADDR), .q(addr_r)
  );

  ncpu32k_ibus_responder_dff #(.DATA_W(32)) bdata_ff (
    .clk(clk), .rst_n(rst_n), .load(ld_resp), .d(resp_data), .q(icache_BDATA)
  );

  ncpu32k_ibus_responder_dff #(.DATA_W(BEXC_W)) bexc_ff (
    .clk(clk), .rst_n(rst_n), .load(ld_resp), .d(resp_exc), .q(icache_BEXC)
  );

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(icache_AVALID && icache_AREADY && icache_AEXC == 2'b11))
        else $error("illegal AEXC=2'b11 accepted");
      assert (!(mem_BVALID && state != ST_MEM_A && state != ST_MEM_B))
        else $error("mem_BVALID outside a memory transaction");
    end
  end
`endif

endmodule

// File: tb/tb_ncpu32k_ibus_responder.sv
// Randomized bench for the ibus responder with a response scoreboard and a
// behavioural memory responder.
module tb_ncpu32k_ibus_responder;

  localparam logic [31:0] EXC_INSN = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_AVALID = 1'b0;
  logic        icache_AREADY;
  logic [31:0] icache_AADDR = '0;
  logic [1:0]  icache_AEXC = '0;
  logic        icache_BVALID;
  logic        icache_BREADY = 1'b0;
  logic [31:0] icache_BDATA;
  logic [2:0]  icache_BEXC;
  logic        mem_AVALID;
  logic        mem_AREADY = 1'b0;
  logic [31:0] mem_AADDR;
  logic        mem_BVALID = 1'b0;
  logic [31:0] mem_BDATA = '0;

  ncpu32k_ibus_responder #(
    .CONFIG_EXC_INSN(EXC_INSN),
    .CONFIG_PIPEBUF_BYPASS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_AVALID(icache_AVALID), .icache_AREADY(icache_AREADY),
    .icache_AADDR(icache_AADDR), .icache_AEXC(icache_AEXC),
    .icache_BVALID(icache_BVALID), .icache_BREADY(icache_BREADY),
    .icache_BDATA(icache_BDATA), .icache_BEXC(icache_BEXC),
    .mem_AVALID(mem_AVALID), .mem_AREADY(mem_AREADY), .mem_AADDR(mem_AADDR),
    .mem_BVALID(mem_BVALID), .mem_BDATA(mem_BDATA)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  e;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, last_lat = -1, n_acc = 0, n_resp = 0, n_mhs = 0;
  int          n_mstall = 0, n_bstall = 0;
  bit          head_seen = 0;
  bit          av_pend = 0;
  logic [31:0] cur_addr = '0;
  logic [1:0]  cur_exc = '0;
  int          auto_req = 0, k_bready = 0, k_mready = 0, k_md = -1;
  int          blow = 0, mstall = 0, mcnt = 0;
  logic [31:0] maddr = '0;
  bit          mem_expected = 0;
  logic [31:0] mem_exp_addr = '0;
  bit          hold_b = 0, hold_m = 0;
  logic [31:0] pb_d = '0, pm_a = '0;
  logic [2:0]  pb_e = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Expected response derived only from the request fields.
  function automatic exp_t model(input logic [31:0] a, input logic [1:0] x, input int c);
    exp_t r;
    r.acc = c;
    if (x != 2'b00) begin
      r.e = {1'b0, x}; r.d = EXC_INSN;
`ifdef NCPU_IBUS_RESP_ALIGN_CHECK_EN
    end else if (a[1:0] != 2'b00) begin
      r.e = 3'b100; r.d = EXC_INSN;
`endif
    end else begin
      r.e = 3'b000; r.d = mem_word({a[31:2], 2'b00});
    end
    return r;
  endfunction

  task automatic sample();
    exp_t e;
    if (hold_b) begin
      check("b_hold_valid", {31'b0, icache_BVALID}, 32'd1);
      check("b_hold_data", icache_BDATA, pb_d);
      check("b_hold_exc", {29'b0, icache_BEXC}, {29'b0, pb_e});
    end
    if (hold_m) begin
      check("m_hold_valid", {31'b0, mem_AVALID}, 32'd1);
      check("m_hold_addr", mem_AADDR, pm_a);
    end
    if (mem_AVALID) check("mem_req_expected", {31'b0, mem_expected}, 32'd1);
    if (mem_AVALID && mem_AREADY) begin
      check("mem_addr", mem_AADDR, mem_exp_addr);
      mem_expected = 0;
      n_mhs++;
    end
    if (mem_AVALID && !mem_AREADY) n_mstall++;
    if (icache_BVALID && !icache_BREADY) n_bstall++;
    if (icache_BVALID) begin
      if (q.size() == 0) check("spurious_bvalid", 32'd1, 32'd0);
      else if (!head_seen) begin
        head_seen = 1;
        last_lat = cyc - q[0].acc;
      end
    end
    if (icache_BVALID && icache_BREADY && q.size() != 0) begin
      e = q.pop_front();
      head_seen = 0;
      n_resp++;
      check("bdata", icache_BDATA, e.d);
      check("bexc", {29'b0, icache_BEXC}, {29'b0, e.e});
      if (icache_AVALID) check("bypass_aready", {31'b0, icache_AREADY}, 32'd1);
    end
    if (icache_AVALID && icache_AREADY) begin
      check("single_outstanding", q.size(), 32'd0);
      e = model(icache_AADDR, icache_AEXC, cyc);
      q.push_back(e);
      if (e.e == 3'b000) begin
        mem_expected = 1;
        mem_exp_addr = {icache_AADDR[31:2], 2'b00};
      end
      av_pend = 0;
      n_acc++;
    end
    hold_b = icache_BVALID && !icache_BREADY;
    pb_d   = icache_BDATA;
    pb_e   = icache_BEXC;
    hold_m = mem_AVALID && !mem_AREADY;
    pm_a   = mem_AADDR;
  endtask

  task automatic drive();
    int d;
    @(posedge clk); #1;
    cyc++;
    if (!av_pend) begin
      if (auto_req == 1 && $urandom_range(0, 2) != 0) begin
        av_pend  = 1;
        cur_addr = $urandom;
        d = int'($urandom_range(0, 5));
        cur_exc  = (d == 4) ? 2'b01 : (d == 5) ? 2'b10 : 2'b00;
      end else if (auto_req == 2) begin
        av_pend  = 1;
        cur_addr = $urandom;
        cur_exc  = 2'($urandom_range(1, 2));
      end
    end
    icache_AVALID = av_pend;
    icache_AADDR  = cur_addr;
    icache_AEXC   = cur_exc;
    if (blow > 0 && icache_BVALID) begin
      icache_BREADY = 1'b0;
      blow--;
    end else begin
      icache_BREADY = (k_bready != 0) || ($urandom_range(0, 3) != 0);
    end
    mem_AREADY = 1'b0;
    mem_BVALID = 1'b0;
    mem_BDATA  = $urandom;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        mem_BVALID = 1'b1;
        mem_BDATA  = mem_word(maddr);
      end
    end else if (mem_AVALID) begin
      if (mstall > 0) mstall--;
      else mem_AREADY = (k_mready != 0) || ($urandom_range(0, 2) != 0);
      if (mem_AREADY) begin
        maddr = mem_AADDR;
        d = (k_md >= 0) ? k_md : int'($urandom_range(0, 3));
        if (d == 0) begin
          mem_BVALID = 1'b1;
          mem_BDATA  = mem_word(maddr);
        end else begin
          mcnt = d;
        end
      end
    end
    #1;
    sample();
  endtask

  task automatic run_until_idle(input int maxc);
    int i;
    i = 0;
    while ((q.size() != 0 || av_pend) && i < maxc) begin
      drive();
      i++;
    end
    if (q.size() != 0 || av_pend) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] x);
    av_pend  = 1;
    cur_addr = a;
    cur_exc  = x;
    run_until_idle(60);
  endtask

  initial begin
    int a0, s0, b0, r0;
    #12;
    check("rst_aready", {31'b0, icache_AREADY}, 32'd1);
    check("rst_bvalid", {31'b0, icache_BVALID}, 32'd0);
    check("rst_bdata", icache_BDATA, 32'd0);
    check("rst_bexc", {29'b0, icache_BEXC}, 32'd0);
    check("rst_mem_avalid", {31'b0, mem_AVALID}, 32'd0);
    check("rst_mem_aaddr", mem_AADDR, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Zero-wait memory fetch and a TLB-miss short circuit.
    k_bready = 1; k_mready = 1; k_md = 0;
    issue(32'h0000_1004, 2'b00);
    check("lat_mem_zero_wait", last_lat, 32'd2);
    a0 = n_mhs;
    issue(32'h8000_0000, 2'b01);
    check("lat_exc", last_lat, 32'd1);
    check("exc_no_mem", n_mhs, a0);

    // Memory stalled four cycles, response held three cycles.
    s0 = n_mstall; b0 = n_bstall;
    mstall = 4; blow = 3; k_md = 1;
    issue(32'h0000_0ABC, 2'b00);
    check("mem_stall_cycles", n_mstall - s0, 32'd4);
    check("b_stall_cycles", n_bstall - b0, 32'd3);

    // Back-to-back exception responses through the bypass path.
    a0 = n_acc;
    auto_req = 2;
    for (int i = 0; i < 10; i++) drive();
    check("b2b_accepts", n_acc - a0, 32'd10);
    auto_req = 0;
    run_until_idle(60);

    // Misaligned fetches, with and without a preceding MMU exception.
    k_md = 0;
    a0 = n_mhs;
    issue(32'h0000_2002, 2'b00);
`ifdef NCPU_IBUS_RESP_ALIGN_CHECK_EN
    check("misalign_no_mem", n_mhs, a0);
`else
    check("misalign_mem", n_mhs, a0 + 1);
`endif
    issue(32'h0000_2002, 2'b10);

    // Asynchronous reset while waiting for memory data.
    k_md = 6;
    a0 = n_mhs;
    av_pend = 1; cur_addr = 32'h0000_4000; cur_exc = 2'b00;
    for (int i = 0; i < 20 && n_mhs == a0; i++) drive();
    check("reset_reached_mem", n_mhs, a0 + 1);
    drive();
    #1 rst_n = 1'b0;
    #1;
    check("arst_aready", {31'b0, icache_AREADY}, 32'd1);
    check("arst_bvalid", {31'b0, icache_BVALID}, 32'd0);
    check("arst_mem_avalid", {31'b0, mem_AVALID}, 32'd0);
    q.delete();
    mem_expected = 0; mcnt = 0; av_pend = 0; head_seen = 0;
    hold_b = 0; hold_m = 0;
    icache_AVALID = 1'b0; mem_AREADY = 1'b0; mem_BVALID = 1'b0;
    n_acc = n_resp;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    k_md = 1;
    r0 = n_resp;
    issue(32'h0000_3008, 2'b00);
    check("post_reset_resp", n_resp - r0, 32'd1);

    // Randomized traffic.
    k_bready = 0; k_mready = 0; k_md = -1; auto_req = 1;
    for (int i = 0; i < 3000; i++) drive();
    auto_req = 0;
    run_until_idle(200);
    check("drain_empty", q.size(), 32'd0);
    check("resp_count", n_resp, n_acc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
